// File: rtl/ps2_keycode_rx_if.sv
// ps2_keycode_rx_if
//  Groups the raw PS/2 keyboard lines with the decoded keycode outputs.
//  master: the receiver (samples the PS/2 lines, drives key/key_valid/frame_err).
//  slave : the keyboard/checker side (drives the PS/2 lines, observes the keycode).
interface ps2_keycode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic       key_valid;
  logic       frame_err;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output key,
    output key_valid,
    output frame_err
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  key,
    input  key_valid,
    input  frame_err
  );
endinterface

// File: rtl/ps2_keycode_rx.sv
// ps2_keycode_rx
//  PS/2 keyboard receiver. Synchronises the raw keyboard clock/data lines,
//  deframes 11-bit frames (start, 8 data LSB first, odd parity, stop), drops
//  E0 prefixes and F0-prefixed break codes, and presents each make code on
//  key with a one-cycle key_valid strobe. Framing, parity and inactivity
//  timeout errors produce a one-cycle frame_err strobe.
//  Optional build macro: PS2_PARITY_CHK_EN -- when defined, a parity mismatch
//  rejects the byte with frame_err; otherwise the parity bit is ignored.
module ps2_keycode_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  ps2_keycode_rx_if.master   bus
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_PARITY_CHK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                 state_q, state_d;

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] data_sync_q;
  logic                   clk_prev_q;
  logic                   ps2_clk_s;
  logic                   ps2_data_s;
  logic                   fall;

  logic [7:0]             shift_q, shift_d;
  logic [2:0]             bitcnt_q, bitcnt_d;
  logic                   par_q, par_d;
  logic                   brk_q, brk_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic [7:0]             key_q, key_d;
  logic                   key_valid_q, key_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   par_ok;
  logic                   tmo_hit;

  assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
  // A keyboard clock fall is a 1->0 change of the synchronised line between cycles.
  assign fall       = clk_prev_q & ~ps2_clk_s;

  // Synchronisers and edge-detect history, preset to the idle-high line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], bus.ps2_clk};
      data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], bus.ps2_data};
      clk_prev_q  <= ps2_clk_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, deframing, byte filtering and timeout decisions.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    par_d       = par_q;
    brk_d       = brk_q;
    key_d       = key_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;

    // Odd parity over data + parity bit; ignored unless the checker is built in.
    par_ok  = !PAR_CHK || (^{shift_q, par_q});
    // A fall in the same cycle as the timeout keeps the frame alive.
    tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TMO_LAST);

    if ((state_q == IDLE) || fall) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end

    if (tmo_hit) begin
      // Abort the partial frame; the break flag survives.
      state_d     = IDLE;
      frame_err_d = 1'b1;
      tmo_d       = '0;
      shift_d     = '0;
      bitcnt_d    = '0;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!ps2_data_s) begin
            state_d  = DATA;
            bitcnt_d = '0;
            shift_d  = '0;
          end
        end
        DATA: begin
          shift_d  = {ps2_data_s, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = ps2_data_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (ps2_data_s && par_ok) begin
            if (shift_q == 8'hE0) begin
              brk_d = brk_q;
            end else if (shift_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (brk_q) begin
              brk_d = 1'b0;
            end else begin
              key_d       = shift_q;
              key_valid_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      bitcnt_q    <= '0;
      par_q       <= 1'b0;
      brk_q       <= 1'b0;
      tmo_q       <= '0;
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      par_q       <= par_d;
      brk_q       <= brk_d;
      tmo_q       <= tmo_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.key       = key_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb_ps2_keycode_rx
//  Drives PS/2 frames into ps2_keycode_rx and compares the strobes and keycode
//  with a frame-level model of the keyboard protocol (make/break/extended).
module tb_ps2_keycode_rx;

  localparam int SYNC = 2;
  localparam int TMO  = 300;
  localparam int HALF = 10;

`ifdef PS2_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_keycode_rx_if bus ();

  ps2_keycode_rx #(
    .SYNC_STAGES   (SYNC),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests_run = 0;
  int fails     = 0;

  // Cycle counter and output monitor.
  int         cyc      = 0;
  int         vld_cnt  = 0;
  int         err_cnt  = 0;
  int         both_cnt = 0;
  int         vld_cyc  = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.key_valid === 1'b1) begin
      vld_cnt = vld_cnt + 1;
      vld_cyc = cyc;
    end
    if (bus.frame_err === 1'b1) err_cnt = err_cnt + 1;
    if (bus.key_valid === 1'b1 && bus.frame_err === 1'b1) both_cnt = both_cnt + 1;
  end

  // Frame-level reference model.
  logic [7:0] m_key = 8'h00;
  bit         m_brk = 1'b0;
  int         exp_v = 0;
  int         exp_e = 0;

  task automatic model_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok);
    int ev;
    int ee;
    ev = 0;
    ee = 0;
    if (!stop_ok || (PCHK && !par_ok)) ee = 1;
    else if (b == 8'hE0) ev = 0;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (m_brk) m_brk = 1'b0;
    else begin
      m_key = b;
      ev    = 1;
    end
    exp_v = exp_v + ev;
    exp_e = exp_e + ee;
  endtask

  int s_v, s_e, s_b;
  task automatic snap();
    s_v   = vld_cnt;
    s_e   = err_cnt;
    s_b   = both_cnt;
    exp_v = 0;
    exp_e = 0;
  endtask

  // Sends the first nbits of an 11-bit frame; returns the cycle of the last fall.
  task automatic send_frame(input logic [7:0] b, input bit pflip, input bit stopb,
                            input int nbits, output int fall_cyc);
    logic [10:0] fr;
    fr = {stopb, (~^b) ^ pflip, b, 1'b0};
    fall_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      bus.ps2_data = fr[i];
      repeat (HALF/2) @(negedge clk);
      bus.ps2_clk = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (HALF/2) @(negedge clk);
    end
    bus.ps2_data = 1'b1;
  endtask

  task automatic settle();
    repeat (3*HALF) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    rst_n        = 1'b0;
    repeat (5) @(negedge clk);
    tests_run++; if (bus.key !== 8'h00) begin fails++; $display("FAIL reset_key got=%h exp=00", bus.key); end
    tests_run++; if (bus.key_valid !== 1'b0) begin fails++; $display("FAIL reset_key_valid got=%b exp=0", bus.key_valid); end
    tests_run++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int fc;
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, 11, fc);
    model_frame(8'h1C, 1'b1, 1'b1);
    settle();
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL basic_valid_cycles got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (err_cnt - s_e !== exp_e) begin fails++; $display("FAIL basic_err got=%0d exp=%0d", err_cnt - s_e, exp_e); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL basic_key got=%h exp=%h", bus.key, m_key); end
    tests_run++; if (vld_cyc - fc !== SYNC + 1) begin fails++; $display("FAIL basic_latency got=%0d exp=%0d", vld_cyc - fc, SYNC + 1); end
  endtask

  task automatic test_break();
    int fc;
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, fc); model_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1, 11, fc); model_frame(8'h1C, 1'b1, 1'b1);
    settle();
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL break_no_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL break_key_held got=%h exp=%h", bus.key, m_key); end
    snap();
    send_frame(8'h32, 1'b0, 1'b1, 11, fc); model_frame(8'h32, 1'b1, 1'b1);
    settle();
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL break_next_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL break_next_key got=%h exp=%h", bus.key, m_key); end
  endtask

  task automatic test_stop_err();
    int fc;
    snap();
    send_frame(8'h24, 1'b0, 1'b0, 11, fc); model_frame(8'h24, 1'b1, 1'b0);
    settle();
    tests_run++; if (err_cnt - s_e !== exp_e) begin fails++; $display("FAIL stop_err got=%0d exp=%0d", err_cnt - s_e, exp_e); end
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL stop_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL stop_key got=%h exp=%h", bus.key, m_key); end
  endtask

  task automatic test_parity();
    int fc;
    snap();
    send_frame(8'h2B, 1'b1, 1'b1, 11, fc); model_frame(8'h2B, 1'b0, 1'b1);
    settle();
    tests_run++; if (err_cnt - s_e !== exp_e) begin fails++; $display("FAIL parity_err got=%0d exp=%0d", err_cnt - s_e, exp_e); end
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL parity_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL parity_key got=%h exp=%h", bus.key, m_key); end
  endtask

  task automatic test_timeout();
    int fc;
    snap();
    send_frame(8'h5A, 1'b0, 1'b1, 5, fc);
    while (cyc < fc + TMO - 20) @(negedge clk);
    tests_run++; if (err_cnt - s_e !== 0) begin fails++; $display("FAIL timeout_early got=%0d exp=0", err_cnt - s_e); end
    while (cyc < fc + TMO + 40) @(negedge clk);
    tests_run++; if (err_cnt - s_e !== 1) begin fails++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - s_e); end
    tests_run++; if (vld_cnt - s_v !== 0) begin fails++; $display("FAIL timeout_valid got=%0d exp=0", vld_cnt - s_v); end
    snap();
    send_frame(8'h1B, 1'b0, 1'b1, 11, fc); model_frame(8'h1B, 1'b1, 1'b1);
    settle();
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL timeout_next_key got=%h exp=%h", bus.key, m_key); end
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL timeout_next_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    // Break flag must survive an aborted frame.
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, 11, fc); model_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h44, 1'b0, 1'b1, 5, fc);
    repeat (TMO + 40) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b1, 11, fc); model_frame(8'h1B, 1'b1, 1'b1);
    settle();
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL timeout_brk_kept got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
  endtask

  task automatic test_back_to_back();
    int fc;
    snap();
    for (int i = 0; i < 3; i++) begin
      send_frame(8'h1C, 1'b0, 1'b1, 11, fc); model_frame(8'h1C, 1'b1, 1'b1);
    end
    send_frame(8'hE0, 1'b0, 1'b1, 11, fc); model_frame(8'hE0, 1'b1, 1'b1);
    send_frame(8'h75, 1'b0, 1'b1, 11, fc); model_frame(8'h75, 1'b1, 1'b1);
    settle();
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL b2b_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL b2b_key got=%h exp=%h", bus.key, m_key); end
  endtask

  task automatic test_reset_midframe();
    int fc;
    send_frame(8'h66, 1'b0, 1'b1, 5, fc);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.key !== 8'h00) begin fails++; $display("FAIL midrst_key got=%h exp=00", bus.key); end
    tests_run++; if (bus.key_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid got=%b exp=0", bus.key_valid); end
    m_key = 8'h00;
    m_brk = 1'b0;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    snap();
    send_frame(8'h35, 1'b0, 1'b1, 11, fc); model_frame(8'h35, 1'b1, 1'b1);
    settle();
    tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL midrst_next_key got=%h exp=%h", bus.key, m_key); end
    tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL midrst_next_valid got=%0d exp=%0d", vld_cnt - s_v, exp_v); end
    tests_run++; if (err_cnt - s_e !== exp_e) begin fails++; $display("FAIL midrst_next_err got=%0d exp=%0d", err_cnt - s_e, exp_e); end
  endtask

  task automatic test_random();
    int         fc;
    int         r;
    logic [7:0] b;
    bit         pflip;
    bit         stopb;
    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r <= 2) b = 8'hF0;
      else             b = 8'($urandom_range(0, 255));
      pflip = ($urandom_range(0, 7) == 0);
      stopb = ($urandom_range(0, 7) != 0);
      snap();
      send_frame(b, pflip, stopb, 11, fc);
      model_frame(b, !pflip, stopb);
      settle();
      tests_run++; if (vld_cnt - s_v !== exp_v) begin fails++; $display("FAIL rand%0d_valid byte=%h got=%0d exp=%0d", n, b, vld_cnt - s_v, exp_v); end
      tests_run++; if (err_cnt - s_e !== exp_e) begin fails++; $display("FAIL rand%0d_err byte=%h got=%0d exp=%0d", n, b, err_cnt - s_e, exp_e); end
      tests_run++; if (bus.key !== m_key) begin fails++; $display("FAIL rand%0d_key got=%h exp=%h", n, bus.key, m_key); end
    end
    tests_run++; if (both_cnt !== 0) begin fails++; $display("FAIL valid_err_overlap got=%0d exp=0", both_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_break();
    test_stop_err();
    test_parity();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
